// File: rtl/state_sweep_controller_if.sv
// Bus between the sweep controller, the neuron state register and the update unit.
// The master side is the controller; the slave side is memory plus update unit.
interface state_sweep_controller_if #(
  parameter int numwidth = 16,
  parameter int tagbits  = 6
);
  logic [tagbits-1:0]    sr_tag;
  logic                  sr_read_en;
  logic                  sr_write_en;
  logic signed [numwidth:0] sr_v_new;
  logic signed [numwidth:0] sr_u_new;
  logic signed [numwidth:0] sr_v;
  logic signed [numwidth:0] sr_u;
  logic                  upd_valid;
  logic                  upd_ready;
  logic [tagbits-1:0]    upd_tag;
  logic signed [numwidth:0] upd_v;
  logic signed [numwidth:0] upd_u;
  logic                  res_valid;
  logic signed [numwidth:0] res_v;
  logic signed [numwidth:0] res_u;

  modport master (
    output sr_tag, sr_read_en, sr_write_en, sr_v_new, sr_u_new,
    output upd_valid, upd_tag, upd_v, upd_u,
    input  sr_v, sr_u, upd_ready, res_valid, res_v, res_u
  );

  modport slave (
    input  sr_tag, sr_read_en, sr_write_en, sr_v_new, sr_u_new,
    input  upd_valid, upd_tag, upd_v, upd_u,
    output sr_v, sr_u, upd_ready, res_valid, res_v, res_u
  );
endinterface

// File: rtl/state_sweep_controller.sv
// Sweeps every neuron: read state, hand it to the update unit, write the result back.
// Optional macro SPIKE_RESET_EN: threshold crossing resets v, bumps u and pulses spike.
module state_sweep_controller #(
  parameter int numwidth   = 16,
  parameter int tagbits    = 6,
  parameter int numneurons = 2**tagbits,
  parameter logic signed [numwidth:0] VTHRESH = 17'sd7680,
  parameter logic signed [numwidth:0] C_RESET = -17'sd16640,
  parameter logic signed [numwidth:0] D_RESET = 17'sd2048
) (
  input  logic               clk,
  input  logic               syn_reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               spike,
  output logic [tagbits-1:0] spike_tag,
  state_sweep_controller_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD, W1, W2, OFFER, COLLECT, WB, FIN} state_t;

  localparam logic [tagbits-1:0] LAST_TAG = tagbits'(numneurons - 1);
  // The word carries one bit of headroom; stored values clamp to the numwidth-bit range.
  localparam logic signed [numwidth+1:0] SAT_MAX = {3'b000, {(numwidth-1){1'b1}}};
  localparam logic signed [numwidth+1:0] SAT_MIN = {3'b111, {(numwidth-1){1'b0}}};

  state_t                   state_r, next_state_s;
  logic [tagbits-1:0]       tag_r;
  logic signed [numwidth:0] op_v_r, op_u_r;
  logic signed [numwidth:0] wb_v_r, wb_u_r;
  logic                     busy_r, done_r, read_en_r, write_en_r, upd_valid_r;
  logic                     spike_r;
  logic [tagbits-1:0]       spike_tag_r;
  logic                     spike_en_s;
  logic                     hit_s;

  function automatic logic signed [numwidth:0] sat_add(
    input logic signed [numwidth:0] a,
    input logic signed [numwidth:0] b
  );
    logic signed [numwidth+1:0] sum_s;
    sum_s = $signed({a[numwidth], a}) + $signed({b[numwidth], b});
    if (sum_s > SAT_MAX) begin
      sat_add = SAT_MAX[numwidth:0];
    end else if (sum_s < SAT_MIN) begin
      sat_add = SAT_MIN[numwidth:0];
    end else begin
      sat_add = sum_s[numwidth:0];
    end
  endfunction

`ifdef SPIKE_RESET_EN
  assign spike_en_s = 1'b1;
`else
  assign spike_en_s = 1'b0;
`endif

  assign hit_s = spike_en_s && (bus.res_v >= VTHRESH);

  // Next-state logic of the sweep sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (start) next_state_s = RD; else next_state_s = IDLE;
      RD:      next_state_s = W1;
      W1:      next_state_s = W2;
      W2:      next_state_s = OFFER;
      OFFER:   if (upd_valid_r && bus.upd_ready) next_state_s = COLLECT; else next_state_s = OFFER;
      COLLECT: if (bus.res_valid) next_state_s = WB; else next_state_s = COLLECT;
      WB:      if (tag_r < LAST_TAG) next_state_s = RD; else next_state_s = FIN;
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register and control strobes, registered from the next state.
  always_ff @(posedge clk) begin
    if (syn_reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      read_en_r   <= 1'b0;
      write_en_r  <= 1'b0;
      upd_valid_r <= 1'b0;
      spike_r     <= 1'b0;
      tag_r       <= '0;
    end else begin
      state_r     <= next_state_s;
      busy_r      <= (next_state_s != IDLE);
      done_r      <= (next_state_s == FIN);
      read_en_r   <= (next_state_s == RD);
      write_en_r  <= (next_state_s == WB);
      upd_valid_r <= (next_state_s == OFFER);
      spike_r     <= (next_state_s == WB) && hit_s;
      if (state_r == IDLE && start) begin
        tag_r <= '0;
      end else if (state_r == WB && next_state_s == RD) begin
        tag_r <= tag_r + 1'b1;
      end else begin
        tag_r <= tag_r;
      end
    end
  end

  // Operand capture at the end of W2 and result capture at the end of COLLECT.
  always_ff @(posedge clk) begin
    if (syn_reset) begin
      op_v_r      <= '0;
      op_u_r      <= '0;
      wb_v_r      <= '0;
      wb_u_r      <= '0;
      spike_tag_r <= '0;
    end else begin
      if (state_r == W2) begin
        op_v_r <= bus.sr_v;
        op_u_r <= bus.sr_u;
      end
      if (state_r == COLLECT && bus.res_valid) begin
        if (hit_s) begin
          wb_v_r      <= C_RESET;
          wb_u_r      <= sat_add(bus.res_u, D_RESET);
          spike_tag_r <= tag_r;
        end else begin
          wb_v_r      <= bus.res_v;
          wb_u_r      <= bus.res_u;
        end
      end
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign bus.sr_tag      = tag_r;
  assign bus.sr_read_en  = read_en_r;
  assign bus.sr_write_en = write_en_r;
  assign bus.sr_v_new    = wb_v_r;
  assign bus.sr_u_new    = wb_u_r;
  assign bus.upd_valid   = upd_valid_r;
  assign bus.upd_tag     = tag_r;
  assign bus.upd_v       = op_v_r;
  assign bus.upd_u       = op_u_r;

`ifdef SPIKE_RESET_EN
  assign spike     = spike_r;
  assign spike_tag = spike_tag_r;
`else
  assign spike     = 1'b0 & spike_r;
  assign spike_tag = spike_tag_r & '0;
`endif

endmodule

// File: doc/state_sweep_controller.md
STATE_SWEEP_CONTROLLER -- requirements
Module: state_sweep_controller

Interface
REQ-001 SHALL have parameter numwidth, default 16, giving a state word width of numwidth+1 bits: two's complement, 8 fractional bits.
REQ-002 SHALL have parameter tagbits, default 6, the neuron tag width.
REQ-003 SHALL have parameter numneurons, default 2**tagbits, the neurons swept per pass.
REQ-004 SHALL have parameters VTHRESH (default 7680 = 30.0), C_RESET (default -16640 = -65.0) and D_RESET (default 2048 = 8.0), all numwidth+1 bits signed.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL provide the following ports.
- clk  in  1  clock, rising edge.
- syn_reset  in  1  synchronous active-high reset.
- start  in  1  begin one sweep; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a sweep completes.
- sr_tag  out  tagbits  tag driven to the state register.
- sr_read_en  out  1  state register read enable.
- sr_write_en  out  1  state register write enable.
- sr_v_new, sr_u_new  out  numwidth+1  write-back data.
- sr_v, sr_u  in  numwidth+1  registered read data from the state register.
- upd_valid  out  1  operand offer to the update unit.
- upd_ready  in  1  update unit accepts the operands.
- upd_tag  out  tagbits  tag of the offered operands.
- upd_v, upd_u  out  numwidth+1  operand values.
- res_valid  in  1  update result present.
- res_v, res_u  in  numwidth+1  updated state.
- spike  out  1  one-cycle spike pulse (SPIKE_RESET_EN builds only).
- spike_tag  out  tagbits  tag of the spiking neuron.

Function
REQ-007 FSM states SHALL be IDLE, RD, W1, W2, OFFER, COLLECT, WB and FIN.
REQ-008 Transitions:
- IDLE to RD on start, with tag counter set to 0.
- RD to W1 to W2 unconditionally.
- W2 to OFFER.
- OFFER to COLLECT on upd_valid and upd_ready.
- COLLECT to WB on res_valid.
- WB to RD if the tag is below numneurons-1; otherwise WB to FIN with no increment.
- FIN to IDLE.
REQ-009 RD SHALL assert sr_read_en for exactly one cycle with sr_tag equal to the current tag.
REQ-010 Read latency is 2 cycles: sr_v/sr_u SHALL be captured into operand registers on the clock edge that ends W2.
REQ-011 In OFFER, upd_valid=1, and upd_v, upd_u and upd_tag SHALL stay stable until the handshake.
REQ-012 res_valid SHALL be ignored outside COLLECT; res_v and res_u SHALL be captured on the edge that ends COLLECT.
REQ-013 WB SHALL assert sr_write_en for exactly one cycle, with sr_tag equal to the current tag and sr_v_new/sr_u_new equal to the captured results.
REQ-014 sr_tag SHALL hold the current tag in all non-IDLE states; the tag counter SHALL increment on leaving WB to RD.
REQ-015 done SHALL pulse high in FIN only; busy SHALL fall on the same edge that sets the FSM to IDLE.
REQ-016 start SHALL be ignored while busy; a start in IDLE and a reset in the same cycle SHALL resolve to reset.
REQ-017 sr_read_en, sr_write_en, upd_valid, done and spike SHALL never be high in the same cycle, except spike together with sr_write_en.
REQ-018 Cycles per neuron SHALL be 6 plus the upd_ready wait plus the res_valid wait; numneurons=64 with zero waits SHALL complete in 64*6+1 cycles from start to done.

Reset
REQ-019 On syn_reset, the FSM SHALL go to IDLE and the tag counter and operand/result registers to 0.
REQ-020 On syn_reset, all outputs SHALL be 0: busy, done, sr_read_en, sr_write_en, upd_valid, spike, sr_tag, spike_tag and all data outputs.
REQ-021 Reset mid-sweep SHALL abort the sweep with no write and no done; the state register contents are left untouched.

Configuration
REQ-022 With macro SPIKE_RESET_EN defined and signed res_v >= VTHRESH, WB SHALL write sr_v_new=C_RESET and sr_u_new=res_u+D_RESET, saturated to the signed range, and pulse spike with spike_tag equal to the tag.
REQ-023 Without SPIKE_RESET_EN, results SHALL be written back unmodified, and spike and spike_tag SHALL be tied to 0.

Verification
REQ-024 Reset, then start, with upd_ready=1 and res_valid=1 constant, results = operands: SHALL give done at cycle 385, 64 writes to tags 0..63 in order, and memory unchanged.
REQ-025 upd_ready held low 10 cycles in OFFER for tag 5: upd_v/upd_u/upd_tag SHALL stay constant, with no read or write until accepted.
REQ-026 syn_reset asserted in COLLECT of tag 12: next cycle SHALL show all outputs 0 and IDLE, no write to tag 12, and no done.
REQ-027 SPIKE_RESET_EN built, res_v=7680 and res_u=32700 for tag 3: SHALL write v=-16640 and u=32767 (saturated), and pulse spike with spike_tag=3.
REQ-028 Same stimulus without SPIKE_RESET_EN: SHALL write v=7680 and u=32700, and spike SHALL stay 0.
